// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the lap stopwatch: FSM states, time record,
// field widths, digit limits and the carry/borrow helpers.
package stopwatch_pkg;

  localparam int unsigned MSEC_W   = 7;
  localparam int unsigned SEC_W    = 6;
  localparam int unsigned MIN_W    = 6;
  localparam int unsigned HOUR_W   = 5;
  localparam int unsigned MSEC_MAX = 99;
  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HOUR_MAX = 23;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOP, ST_DONE} sw_state_e;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
    logic [MSEC_W-1:0] msec;
  } sw_time_t;

  localparam int unsigned TIME_W = $bits(sw_time_t);

  // One centisecond forward; 23:59:59.99 rolls over to zero.
  function automatic sw_time_t time_inc(input sw_time_t t);
    sw_time_t r;
    r = t;
    if (t.msec != MSEC_W'(MSEC_MAX)) r.msec = t.msec + MSEC_W'(1);
    else begin
      r.msec = '0;
      if (t.sec != SEC_W'(SEC_MAX)) r.sec = t.sec + SEC_W'(1);
      else begin
        r.sec = '0;
        if (t.min != MIN_W'(MIN_MAX)) r.min = t.min + MIN_W'(1);
        else begin
          r.min  = '0;
          r.hour = (t.hour == HOUR_W'(HOUR_MAX)) ? '0 : t.hour + HOUR_W'(1);
        end
      end
    end
    return r;
  endfunction

  // One centisecond backward with borrow; callers never pass zero.
  function automatic sw_time_t time_dec(input sw_time_t t);
    sw_time_t r;
    r = t;
    if (t.msec != '0) r.msec = t.msec - MSEC_W'(1);
    else begin
      r.msec = MSEC_W'(MSEC_MAX);
      if (t.sec != '0) r.sec = t.sec - SEC_W'(1);
      else begin
        r.sec = SEC_W'(SEC_MAX);
        if (t.min != '0) r.min = t.min - MIN_W'(1);
        else begin
          r.min  = MIN_W'(MIN_MAX);
          r.hour = (t.hour == '0) ? HOUR_W'(HOUR_MAX) : t.hour - HOUR_W'(1);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lap_stopwatch_if.sv
// Control/readout bundle of the lap stopwatch; master drives the pulses,
// slave (the stopwatch) drives live time and lap readback.
interface lap_stopwatch_if #(parameter int unsigned N_LAPS = 4);
  import stopwatch_pkg::*;

  localparam int unsigned SEL_W  = (N_LAPS > 1) ? $clog2(N_LAPS) : 1;
  localparam int unsigned LCNT_W = $clog2(N_LAPS + 1);

  logic              i_runstop;
  logic              i_clear;
  logic              i_lap;
  logic              i_mode;
  logic [MIN_W-1:0]  i_preset_min;
  logic [SEC_W-1:0]  i_preset_sec;
  logic [SEL_W-1:0]  i_lap_sel;
  logic [MSEC_W-1:0] o_msec,  o_lap_msec;
  logic [SEC_W-1:0]  o_sec,   o_lap_sec;
  logic [MIN_W-1:0]  o_min,   o_lap_min;
  logic [HOUR_W-1:0] o_hour,  o_lap_hour;
  logic [LCNT_W-1:0] o_lap_count;
  logic              o_running;
  logic              o_done;

  modport master (
    output i_runstop, i_clear, i_lap, i_mode, i_preset_min, i_preset_sec, i_lap_sel,
    input  o_msec, o_sec, o_min, o_hour, o_lap_msec, o_lap_sec, o_lap_min, o_lap_hour,
    input  o_lap_count, o_running, o_done
  );

  modport slave (
    input  i_runstop, i_clear, i_lap, i_mode, i_preset_min, i_preset_sec, i_lap_sel,
    output o_msec, o_sec, o_min, o_hour, o_lap_msec, o_lap_sec, o_lap_min, o_lap_hour,
    output o_lap_count, o_running, o_done
  );

endinterface

// File: rtl/sw_tick_gen.sv
// Centisecond prescaler: one o_tick every CLK_FREQ_HZ/TICK_HZ enabled cycles;
// i_clr zeroes the count, deasserted i_en holds it.
module sw_tick_gen #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned TICK_HZ     = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);
  localparam int unsigned DIV   = CLK_FREQ_HZ / TICK_HZ;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  if (CLK_FREQ_HZ % TICK_HZ != 0) begin : g_bad_div
    $error("CLK_FREQ_HZ must be a multiple of TICK_HZ");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  assign wrap = (cnt_q == CNT_W'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)     cnt_d = '0;
    else if (i_en) cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign o_tick = i_en && !i_clr && wrap;

endmodule

// File: rtl/lap_stopwatch.sv
// Up/down stopwatch with run/stop/clear control and an optional circular lap
// buffer, compiled in only when LAP_STOPWATCH_LAPS_EN is defined.
module lap_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned TICK_HZ     = 100,
  parameter int unsigned N_LAPS      = 4
) (
  input  logic            clk,
  input  logic            rst,
  lap_stopwatch_if.slave  bus
);
  if (N_LAPS < 1 || N_LAPS > 16) begin : g_bad_laps
    $error("N_LAPS must be within 1..16");
  end

  sw_state_e state_q;
  sw_time_t  time_q, time_d, preset;
  logic      mode_q, running_q, done_q;
  logic      clr_ev, rs_ev, tick, zero_now, down_fin;

  assign clr_ev   = bus.i_clear;
  assign rs_ev    = bus.i_runstop && !bus.i_clear;
  assign preset   = '{hour: HOUR_W'(0), min: bus.i_preset_min, sec: bus.i_preset_sec, msec: MSEC_W'(0)};
  assign zero_now = (time_q == '0);
  // Countdown ends either already at zero (0:00 preset) or on the tick leaving .01.
  assign down_fin = mode_q && (zero_now || (tick && time_q == TIME_W'(1)));

  sw_tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .TICK_HZ(TICK_HZ)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_en   (state_q == ST_RUN),
    .i_clr  (clr_ev || state_q == ST_IDLE),
    .o_tick (tick)
  );

  always_comb begin
    time_d = time_q;
    if (clr_ev) time_d = bus.i_mode ? preset : '0;
    else if (state_q == ST_RUN && tick) begin
      if (!mode_q)       time_d = time_inc(time_q);
      else if (!zero_now) time_d = time_dec(time_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      time_q    <= '0;
      mode_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      time_q <= time_d;
      done_q <= 1'b0;
      if (clr_ev) begin
        state_q   <= ST_IDLE;
        running_q <= 1'b0;
        mode_q    <= bus.i_mode;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            mode_q <= bus.i_mode;
            if (rs_ev) begin
              state_q   <= ST_RUN;
              running_q <= 1'b1;
            end
          end
          ST_RUN: begin
            if (down_fin) begin
              state_q   <= ST_DONE;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end else if (rs_ev) begin
              state_q   <= ST_STOP;
              running_q <= 1'b0;
            end
          end
          ST_STOP: begin
            if (rs_ev) begin
              state_q   <= ST_RUN;
              running_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.o_msec    = time_q.msec;
  assign bus.o_sec     = time_q.sec;
  assign bus.o_min     = time_q.min;
  assign bus.o_hour    = time_q.hour;
  assign bus.o_running = running_q;
  assign bus.o_done    = done_q;

`ifdef LAP_STOPWATCH_LAPS_EN
  localparam int unsigned PTR_W  = (N_LAPS > 1) ? $clog2(N_LAPS) : 1;
  localparam int unsigned LCNT_W = $clog2(N_LAPS + 1);

  sw_time_t          lap_q [N_LAPS];
  logic [PTR_W-1:0]  wr_ptr_q, rd_idx;
  logic [LCNT_W-1:0] lap_cnt_q;
  logic              lap_ev, lap_full;
  int unsigned       rd_sum;
  sw_time_t          lap_rd;

  assign lap_ev   = bus.i_lap && !bus.i_clear && !bus.i_runstop &&
                    (state_q == ST_RUN || state_q == ST_STOP);
  assign lap_full = (lap_cnt_q == LCNT_W'(N_LAPS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_LAPS); i++) lap_q[i] <= '0;
      wr_ptr_q  <= '0;
      lap_cnt_q <= '0;
    end else if (clr_ev) begin
      wr_ptr_q  <= '0;
      lap_cnt_q <= '0;
    end else if (lap_ev) begin
      lap_q[wr_ptr_q] <= time_q;
      wr_ptr_q        <= (wr_ptr_q == PTR_W'(N_LAPS - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (!lap_full) lap_cnt_q <= lap_cnt_q + LCNT_W'(1);
    end
  end

  // Once full, the write pointer sits on the oldest entry, so index 0 maps there.
  always_comb begin
    rd_sum = 32'(bus.i_lap_sel) + (lap_full ? 32'(wr_ptr_q) : 32'd0);
    if (rd_sum >= N_LAPS) rd_sum = rd_sum - N_LAPS;
    rd_idx = PTR_W'(rd_sum);
    lap_rd = (32'(bus.i_lap_sel) < 32'(lap_cnt_q)) ? lap_q[rd_idx] : '0;
  end

  assign bus.o_lap_msec  = lap_rd.msec;
  assign bus.o_lap_sec   = lap_rd.sec;
  assign bus.o_lap_min   = lap_rd.min;
  assign bus.o_lap_hour  = lap_rd.hour;
  assign bus.o_lap_count = lap_cnt_q;
`else
  logic lap_unused;
  assign lap_unused      = bus.i_lap ^ (^bus.i_lap_sel);
  assign bus.o_lap_msec  = '0;
  assign bus.o_lap_sec   = '0;
  assign bus.o_lap_min   = '0;
  assign bus.o_lap_hour  = '0;
  assign bus.o_lap_count = '0;
`endif

endmodule

// File: tb/tb_lap_stopwatch.sv
// Self-checking bench for lap_stopwatch; lap expectations follow LAP_STOPWATCH_LAPS_EN.
module tb_lap_stopwatch;
  import stopwatch_pkg::*;

  localparam int unsigned CLK_HZ = 1000;
  localparam int unsigned TICK   = 100;
  localparam int unsigned NL     = 4;
  localparam int          DIV    = int'(CLK_HZ / TICK);
  localparam int          DAY_CS = 24 * 60 * 60 * 100;
`ifdef LAP_STOPWATCH_LAPS_EN
  localparam bit LAPS = 1'b1;
`else
  localparam bit LAPS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   errors  = 0;

  lap_stopwatch_if #(.N_LAPS(NL)) bus ();
  lap_stopwatch #(.CLK_FREQ_HZ(CLK_HZ), .TICK_HZ(TICK), .N_LAPS(NL)) dut (
    .clk (clk), .rst (rst), .bus (bus));

  always #5 clk = ~clk;

  typedef struct {
    bit rs, cl, lp, mode;
    int pmin, psec;
    int exp_cs;
    bit exp_run, exp_done;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int to_cs(input int h, input int m, input int s, input int c);
    return ((h * 60 + m) * 60 + s) * 100 + c;
  endfunction

  function automatic int live_cs();
    return to_cs(int'(bus.o_hour), int'(bus.o_min), int'(bus.o_sec), int'(bus.o_msec));
  endfunction

  task automatic step(input bit rs, input bit cl, input bit lp);
    bus.i_runstop = rs; bus.i_clear = cl; bus.i_lap = lp;
    @(posedge clk); #1;
    bus.i_runstop = 1'b0; bus.i_clear = 1'b0; bus.i_lap = 1'b0;
  endtask

  task automatic read_lap(input int sel, output int cs);
    bus.i_lap_sel = 2'(sel);
    #1;
    cs = to_cs(int'(bus.o_lap_hour), int'(bus.o_lap_min), int'(bus.o_lap_sec), int'(bus.o_lap_msec));
  endtask

  initial begin
    int lap_v, first_done, ndone, e;
    bit run, started;
    int laps[$];

    // rs cl lp mode pmin psec exp_cs run done
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0,     0, 0};
    tbl[1]  = '{0, 1, 0, 1, 3, 7, 18700, 0, 0};
    tbl[2]  = '{0, 0, 0, 1, 5, 1, 18700, 0, 0};
    tbl[3]  = '{1, 1, 0, 0, 5, 1, 0,     0, 0};
    tbl[4]  = '{1, 0, 1, 0, 0, 0, 0,     1, 0};
    tbl[5]  = '{1, 0, 1, 0, 0, 0, 0,     0, 0};
    tbl[6]  = '{0, 1, 0, 1, 0, 0, 0,     0, 0};
    tbl[7]  = '{1, 0, 0, 1, 0, 0, 0,     1, 0};
    tbl[8]  = '{0, 0, 0, 1, 0, 0, 0,     0, 1};
    tbl[9]  = '{1, 0, 0, 1, 0, 0, 0,     0, 0};
    tbl[10] = '{0, 1, 0, 0, 0, 0, 0,     0, 0};

    bus.i_runstop = 0; bus.i_clear = 0; bus.i_lap = 0; bus.i_mode = 0;
    bus.i_preset_min = '0; bus.i_preset_sec = '0; bus.i_lap_sel = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_time", live_cs(), 0);
    check("reset_running", int'(bus.o_running), 0);
    check("reset_done", int'(bus.o_done), 0);
    check("reset_lapcnt", int'(bus.o_lap_count), 0);
    rst = 1'b0;

    // Single-cycle control table: preset load, priority, zero-preset countdown.
    for (int i = 0; i < 11; i++) begin
      bus.i_mode = tbl[i].mode;
      bus.i_preset_min = 6'(tbl[i].pmin);
      bus.i_preset_sec = 6'(tbl[i].psec);
      step(tbl[i].rs, tbl[i].cl, tbl[i].lp);
      check($sformatf("tbl%0d_time", i), live_cs(), tbl[i].exp_cs);
      check($sformatf("tbl%0d_running", i), int'(bus.o_running), int'(tbl[i].exp_run));
      check($sformatf("tbl%0d_done", i), int'(bus.o_done), int'(tbl[i].exp_done));
      check($sformatf("tbl%0d_lapcnt", i), int'(bus.o_lap_count), 0);
    end
    check("tbl_final_state", int'(dut.state_q), int'(ST_IDLE));

    // One minute counting up.
    bus.i_mode = 1'b0;
    step(0, 1, 0);
    step(1, 0, 0);
    repeat (6000 * DIV) step(0, 0, 0);
    check("up_1min_time", live_cs(), to_cs(0, 1, 0, 0));
    check("up_1min_running", int'(bus.o_running), 1);

    // Wrap at end of day, time loaded by backdoor while stopped.
    step(1, 0, 0);
    check("stop_running", int'(bus.o_running), 0);
    force dut.time_q = {5'd23, 6'd59, 6'd59, 7'd99};
    step(0, 0, 0);
    step(0, 0, 0);
    release dut.time_q;
    step(0, 0, 0);
    check("backdoor_time", live_cs(), to_cs(23, 59, 59, 99));
    step(1, 0, 0);
    repeat (DIV) step(0, 0, 0);
    check("wrap_time", live_cs(), 0);
    check("wrap_running", int'(bus.o_running), 1);
    check("wrap_state", int'(dut.state_q), int'(ST_RUN));

    // Countdown from 0:02.
    bus.i_mode = 1'b1; bus.i_preset_min = 6'd0; bus.i_preset_sec = 6'd2;
    step(0, 1, 0);
    check("cd_preset", live_cs(), 200);
    step(1, 0, 0);
    first_done = -1; ndone = 0;
    for (int i = 1; i <= 200 * DIV + 20; i++) begin
      step(0, 0, 0);
      if (bus.o_done) begin
        ndone++;
        if (first_done < 0) first_done = i;
      end
    end
    check("cd_done_cycle", first_done, 200 * DIV);
    check("cd_done_pulses", ndone, 1);
    check("cd_time", live_cs(), 0);
    check("cd_state", int'(dut.state_q), int'(ST_DONE));
    step(1, 0, 0);
    check("cd_rs_state", int'(dut.state_q), int'(ST_DONE));
    check("cd_rs_time", live_cs(), 0);
    check("cd_rs_done", int'(bus.o_done), 0);
    check("cd_rs_running", int'(bus.o_running), 0);

    // Five laps at whole seconds into a four-deep buffer.
    bus.i_mode = 1'b0; bus.i_preset_sec = 6'd0;
    step(0, 1, 0);
    read_lap(0, lap_v);
    check("lap_empty_read", lap_v, 0);
    step(1, 0, 0);
    e = 0;
    for (int k = 1; k <= 5; k++) begin
      while (e < 100 * DIV * k) begin step(0, 0, 0); e++; end
      step(0, 0, 1); e++;
    end
    check("lap_count", int'(bus.o_lap_count), LAPS ? 4 : 0);
    for (int s = 0; s < 4; s++) begin
      read_lap(s, lap_v);
      check($sformatf("lap_idx%0d", s), lap_v, LAPS ? (s + 2) * 100 : 0);
    end

    // Asynchronous reset while running.
    step(0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_time", live_cs(), 0);
    check("arst_running", int'(bus.o_running), 0);
    check("arst_lapcnt", int'(bus.o_lap_count), 0);
    check("arst_state", int'(dut.state_q), int'(ST_IDLE));
    @(posedge clk); #1 rst = 1'b0;
    repeat (3 * DIV) step(0, 0, 0);
    check("arst_hold_time", live_cs(), 0);
    check("arst_hold_running", int'(bus.o_running), 0);
    step(1, 0, 0);
    repeat (DIV) step(0, 0, 0);
    check("arst_restart_time", live_cs(), 1);

    // Random run/stop/lap traffic against an elapsed-cycle model.
    step(0, 1, 0);
    run = 0; started = 0; e = 0;
    laps.delete();
    for (int n = 0; n < 600; n++) begin
      bit rs, lp;
      int sel, exp_lap;
      rs = ($urandom_range(0, 24) == 0);
      lp = ($urandom_range(0, 6) == 0);
      step(rs, 1'b0, lp);
      if (lp && !rs && started) begin
        laps.push_back(e / DIV);
        if (laps.size() > NL) void'(laps.pop_front());
      end
      if (run) e++;
      if (rs) begin run = !run; started = 1; end
      check("rnd_time", live_cs(), (e / DIV) % DAY_CS);
      check("rnd_running", int'(bus.o_running), int'(run));
      check("rnd_lapcnt", int'(bus.o_lap_count), LAPS ? laps.size() : 0);
      sel = $urandom_range(0, NL - 1);
      exp_lap = (LAPS && sel < laps.size()) ? laps[sel] : 0;
      read_lap(sel, lap_v);
      check("rnd_lap", lap_v, exp_lap);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
